// File: rtl/hrdsc_ifb_pkg.sv
// Shared entry layout and fetch status codes for the instruction fetch buffer.
package hrdsc_ifb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STATUS_W  = 3;
    localparam int unsigned PRED_W    = 3;
    localparam int unsigned IFB_WIDTH = PRED_W + STATUS_W + DATA_W;

    localparam logic [STATUS_W-1:0] FETCH_VALID = 3'd0;
    localparam logic [STATUS_W-1:0] FETCH_INCER = 3'd7;

    typedef struct packed {
        logic [PRED_W-1:0]   pred;
        logic [STATUS_W-1:0] status;
        logic [DATA_W-1:0]   data;
    } ifb_entry_t;

endpackage

// File: rtl/hrdsc_ifb.sv
// Instruction fetch buffer: small FIFO of fetched words between FE and ID,
// emptied on redirect; full/empty are tracked by an explicit entry count.
module hrdsc_ifb
    import hrdsc_ifb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    s_clk_i,
    input  logic                    s_resetn_i,
    input  logic                    s_flush_i,
    input  logic                    s_fe_valid_i,
    output logic                    s_fe_ready_o,
    input  logic [DATA_W-1:0]       s_fe_data_i,
    input  logic [STATUS_W-1:0]     s_fe_status_i,
    input  logic [PRED_W-1:0]       s_fe_pred_i,
    output logic                    s_id_valid_o,
    input  logic                    s_id_ready_i,
    output logic [IFB_WIDTH-1:0]    s_id_entry_o,
    output logic                    s_id_err_o,
    output logic [$clog2(DEPTH):0]  s_occupancy_o,
    output logic                    s_cerr_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ifb_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_fe_ready;
    logic               r_cerr;

    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    ifb_entry_t         w_wr_entry;
    ifb_entry_t         w_head;

    // Flush wins over both transfers; ready is the registered view of count only.
    assign w_empty    = (r_count == '0);
    assign w_push     = s_fe_valid_i & r_fe_ready & ~s_flush_i;
    assign w_pop      = ~w_empty & s_id_ready_i & ~s_flush_i;
    assign w_wr_entry = {s_fe_pred_i, s_fe_status_i, s_fe_data_i};

    always_comb begin
        w_count_nxt = r_count;
        if (s_flush_i) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fe_ready <= 1'b0;
            r_cerr     <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_fe_ready <= (w_count_nxt != FULL_CNT);
            r_cerr     <= w_push && (s_fe_status_i == FETCH_INCER);
            if (s_flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Entry storage carries no reset; only the pointers define what is live.
    always_ff @(posedge s_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Head is forced to zero when empty so stale or unwritten storage never leaks out.
    assign w_head = w_empty ? ifb_entry_t'('0) : r_mem[r_rd_ptr];

    assign s_fe_ready_o  = r_fe_ready;
    assign s_id_valid_o  = ~w_empty;
    assign s_id_entry_o  = w_head;
    assign s_id_err_o    = ~w_empty && (w_head.status != FETCH_VALID)
                                    && (w_head.status != FETCH_INCER);
    assign s_occupancy_o = r_count;
    assign s_cerr_o      = r_cerr;

endmodule
